// File: rtl/machine_timer_pkg.sv
// -----------------------------------------------------------------------------
// machine_timer_pkg
// Shared definitions for the machine timer register block: register offsets
// (word index taken from ram_addr[4:2]), CTRL field positions, reset values
// and the byte-lane merge helper used for partial writes.
// -----------------------------------------------------------------------------
package machine_timer_pkg;

    localparam int REG_W = 32;

    // Word offsets (byte offset >> 2)
    localparam logic [2:0] OFF_MTIME_LO    = 3'd0;  // 0x00
    localparam logic [2:0] OFF_MTIME_HI    = 3'd1;  // 0x04
    localparam logic [2:0] OFF_MTIMECMP_LO = 3'd2;  // 0x08
    localparam logic [2:0] OFF_MTIMECMP_HI = 3'd3;  // 0x0C
    localparam logic [2:0] OFF_CTRL        = 3'd4;  // 0x10
    localparam logic [2:0] OFF_MSIP        = 3'd5;  // 0x14 (optional)

    // CTRL fields
    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_DIV_LSB = 8;
    localparam int CTRL_DIV_W   = 8;

    // Reset values
    localparam logic [63:0]           MTIME_RST    = 64'h0;
    localparam logic [63:0]           MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic                  CTRL_EN_RST  = 1'b0;
    localparam logic [CTRL_DIV_W-1:0] CTRL_DIV_RST = '0;
    localparam logic                  MSIP_RST     = 1'b0;

    // Replace only the bytes whose select bit is set.
    function automatic logic [REG_W-1:0] merge_bytes(
        input logic [REG_W-1:0] old_val,
        input logic [REG_W-1:0] new_val,
        input logic [3:0]       sel
    );
        logic [REG_W-1:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/machine_timer_if.sv
// -----------------------------------------------------------------------------
// machine_timer_if
// Core data-bus connection to the machine timer.
//   ram_ce      : request strobe          ram_we      : 1 write / 0 read
//   ram_sel     : byte enables            ram_addr    : byte address
//   ram_data_in : write data              tmr_data    : registered read data
//   tmr_rvalid  : read data valid (one cycle after a selected read)
// Modports: master (core side), slave (timer side).
// -----------------------------------------------------------------------------
interface machine_timer_if #(
    parameter int WIDTH = 32
);
    logic             ram_ce;
    logic             ram_we;
    logic [3:0]       ram_sel;
    logic [WIDTH-1:0] ram_addr;
    logic [WIDTH-1:0] ram_data_in;
    logic [WIDTH-1:0] tmr_data;
    logic             tmr_rvalid;

    modport master (
        output ram_ce, ram_we, ram_sel, ram_addr, ram_data_in,
        input  tmr_data, tmr_rvalid
    );

    modport slave (
        input  ram_ce, ram_we, ram_sel, ram_addr, ram_data_in,
        output tmr_data, tmr_rvalid
    );
endinterface

// File: rtl/machine_timer_prescaler.sv
// -----------------------------------------------------------------------------
// machine_timer_prescaler
// Produces a one-cycle tick every DIV+1 cycles while enabled.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : prescaler enable; counter held at 0 while low
//   div        : divide value; 0 ticks every cycle
//   tick       : combinational tick (en && count == div)
// -----------------------------------------------------------------------------
module machine_timer_prescaler
    import machine_timer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [CTRL_DIV_W-1:0] div,
    output logic                  tick
);

    logic [CTRL_DIV_W-1:0] cnt_q;
    logic [CTRL_DIV_W-1:0] cnt_d;

    assign tick = en && (cnt_q == div);

    // If DIV is lowered below the current count, the counter runs up and
    // wraps through zero before the next tick.
    always_comb begin
        cnt_d = cnt_q;
        if (!en || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CTRL_DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/machine_timer.sv
// -----------------------------------------------------------------------------
// machine_timer
// Memory-mapped 64-bit machine timer with compare interrupt.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : machine_timer_if.slave (core data-bus request / read data)
//   irq_timer  : level interrupt, registered (mtime >= mtimecmp)
//   irq_sw     : software interrupt from MSIP bit0, registered
//                (only with MACHINE_TIMER_MSIP_EN defined)
// Register map (byte offset from BASE_ADDR):
//   0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI,
//   0x10 CTRL (bit0 EN, bits[15:8] DIV), 0x14 MSIP (MACHINE_TIMER_MSIP_EN)
// The register map is 32 bits wide; WIDTH is expected to be 32.
// -----------------------------------------------------------------------------
module machine_timer
    import machine_timer_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000
) (
    input  logic           clk,
    input  logic           rst_n,
    machine_timer_if.slave bus,
    output logic           irq_timer
`ifdef MACHINE_TIMER_MSIP_EN
    ,
    output logic           irq_sw
`endif
);

    logic             sel_hit;
    logic [2:0]       off;
    logic             wr_en;
    logic             rd_en;
    logic             tick;
    logic             unused_addr_bits;

    logic [WIDTH-1:0] mtime_lo_q, mtime_lo_d;
    logic [WIDTH-1:0] mtime_hi_q, mtime_hi_d;
    logic [WIDTH-1:0] cmp_lo_q, cmp_lo_d;
    logic [WIDTH-1:0] cmp_hi_q, cmp_hi_d;
    logic             ctrl_en_q, ctrl_en_d;
    logic [CTRL_DIV_W-1:0] ctrl_div_q, ctrl_div_d;
    logic [2*WIDTH-1:0] mtime_inc;

    logic [WIDTH-1:0] rd_val;
    logic [WIDTH-1:0] tmr_data_q, tmr_data_d;
    logic             rvalid_q;
    logic             irq_q, irq_d;

`ifdef MACHINE_TIMER_MSIP_EN
    logic             msip_q, msip_d;
    logic             irq_sw_q;
`endif

    assign sel_hit = bus.ram_ce && (bus.ram_addr[31:5] == BASE_ADDR[31:5]);
    assign off     = bus.ram_addr[4:2];
    assign wr_en   = sel_hit && bus.ram_we;
    assign rd_en   = sel_hit && !bus.ram_we;
    assign unused_addr_bits = ^bus.ram_addr[1:0];

    machine_timer_prescaler u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ctrl_en_q),
        .div   (ctrl_div_q),
        .tick  (tick)
    );

    assign mtime_inc = {mtime_hi_q, mtime_lo_q} + (2*WIDTH)'(1);

    // Next-state for the register file. A bus write to either mtime half
    // replaces the tick for that cycle: the written half takes the merged
    // bytes and the other half keeps its pre-tick value.
    always_comb begin
        mtime_lo_d = mtime_lo_q;
        mtime_hi_d = mtime_hi_q;
        cmp_lo_d   = cmp_lo_q;
        cmp_hi_d   = cmp_hi_q;
        ctrl_en_d  = ctrl_en_q;
        ctrl_div_d = ctrl_div_q;
`ifdef MACHINE_TIMER_MSIP_EN
        msip_d     = msip_q;
`endif
        if (tick) begin
            {mtime_hi_d, mtime_lo_d} = mtime_inc;
        end
        if (wr_en) begin
            case (off)
                OFF_MTIME_LO: begin
                    mtime_lo_d = merge_bytes(mtime_lo_q, bus.ram_data_in, bus.ram_sel);
                    mtime_hi_d = mtime_hi_q;
                end
                OFF_MTIME_HI: begin
                    mtime_hi_d = merge_bytes(mtime_hi_q, bus.ram_data_in, bus.ram_sel);
                    mtime_lo_d = mtime_lo_q;
                end
                OFF_MTIMECMP_LO: cmp_lo_d = merge_bytes(cmp_lo_q, bus.ram_data_in, bus.ram_sel);
                OFF_MTIMECMP_HI: cmp_hi_d = merge_bytes(cmp_hi_q, bus.ram_data_in, bus.ram_sel);
                OFF_CTRL: begin
                    if (bus.ram_sel[0]) ctrl_en_d  = bus.ram_data_in[CTRL_EN_BIT];
                    if (bus.ram_sel[1]) ctrl_div_d = bus.ram_data_in[CTRL_DIV_LSB +: CTRL_DIV_W];
                end
`ifdef MACHINE_TIMER_MSIP_EN
                OFF_MSIP: begin
                    if (bus.ram_sel[0]) msip_d = bus.ram_data_in[0];
                end
`endif
                default: ;
            endcase
        end
    end

    // Read mux works on the current (pre-edge) register values.
    always_comb begin
        rd_val = '0;
        case (off)
            OFF_MTIME_LO:    rd_val = mtime_lo_q;
            OFF_MTIME_HI:    rd_val = mtime_hi_q;
            OFF_MTIMECMP_LO: rd_val = cmp_lo_q;
            OFF_MTIMECMP_HI: rd_val = cmp_hi_q;
            OFF_CTRL: begin
                rd_val[CTRL_EN_BIT]                    = ctrl_en_q;
                rd_val[CTRL_DIV_LSB +: CTRL_DIV_W]     = ctrl_div_q;
            end
`ifdef MACHINE_TIMER_MSIP_EN
            OFF_MSIP:        rd_val[0] = msip_q;
`endif
            default:         rd_val = '0;
        endcase
    end

    always_comb begin
        tmr_data_d = tmr_data_q;
        if (rd_en) tmr_data_d = rd_val;
        irq_d = ({mtime_hi_q, mtime_lo_q} >= {cmp_hi_q, cmp_lo_q});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {mtime_hi_q, mtime_lo_q} <= MTIME_RST;
            {cmp_hi_q, cmp_lo_q}     <= MTIMECMP_RST;
            ctrl_en_q                <= CTRL_EN_RST;
            ctrl_div_q               <= CTRL_DIV_RST;
            tmr_data_q               <= '0;
            rvalid_q                 <= 1'b0;
            irq_q                    <= 1'b0;
        end else begin
            mtime_lo_q <= mtime_lo_d;
            mtime_hi_q <= mtime_hi_d;
            cmp_lo_q   <= cmp_lo_d;
            cmp_hi_q   <= cmp_hi_d;
            ctrl_en_q  <= ctrl_en_d;
            ctrl_div_q <= ctrl_div_d;
            tmr_data_q <= tmr_data_d;
            rvalid_q   <= rd_en;
            irq_q      <= irq_d;
        end
    end

`ifdef MACHINE_TIMER_MSIP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msip_q   <= MSIP_RST;
            irq_sw_q <= 1'b0;
        end else begin
            msip_q   <= msip_d;
            irq_sw_q <= msip_q;
        end
    end

    assign irq_sw = irq_sw_q;
`endif

    assign bus.tmr_data   = tmr_data_q;
    assign bus.tmr_rvalid = rvalid_q;
    assign irq_timer      = irq_q;

endmodule

// File: doc/machine_timer.md
MACHINE_TIMER -- requirements
Module: machine_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning bus data/address width.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0001_0000, meaning register block base, 32-byte aligned.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port ram_ce, input, 1, meaning core data-bus request strobe.
REQ-006 SHALL have port ram_we, input, 1, meaning write (1) or read (0).
REQ-007 SHALL have port ram_sel, input, 4, meaning byte enables, bit n for byte n.
REQ-008 SHALL have port ram_addr, input, WIDTH, meaning byte address.
REQ-009 SHALL have port ram_data_in, input, WIDTH, meaning write data.
REQ-010 SHALL have port tmr_data, output, WIDTH, meaning read data.
REQ-011 SHALL have port tmr_rvalid, output, 1, meaning read data valid.
REQ-012 SHALL have port irq_timer, output, 1, meaning level timer interrupt to core_top.

Function
REQ-013 SHALL select the block when ram_ce=1 and ram_addr[31:5]==BASE_ADDR[31:5]; offset = ram_addr[4:2].
REQ-014 SHALL map registers: 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI, 0x10 CTRL (bit0 EN, bits[15:8] DIV, others read 0).
REQ-015 SHALL write only the bytes whose ram_sel bit is 1, taking effect at the request edge.
REQ-016 SHALL ignore writes to undefined offsets; reads of undefined offsets SHALL return 0.
REQ-017 SHALL register read data: tmr_data and tmr_rvalid=1 in the cycle after a selected read, with tmr_rvalid=0 otherwise.
REQ-018 SHALL return, for a read, the register value before any update at the request edge.
REQ-019 SHALL hold tmr_data at its last value when tmr_rvalid=0.
REQ-020 SHALL tick when EN=1 and the prescale counter equals DIV; the counter then clears, otherwise it increments; DIV=0 SHALL tick every cycle.
REQ-021 SHALL hold the prescale counter at 0 while EN=0.
REQ-022 SHALL increment the 64-bit mtime by 1 per tick, with carry from LO into HI, wrapping all-ones to 0.
REQ-023 SHALL give a bus write to MTIME_LO/HI priority over a tick in the same cycle; the written half takes the written bytes and the other half is unchanged.
REQ-024 SHALL drive irq_timer one cycle after (mtime >= mtimecmp), compared as 64-bit unsigned on registered values.
REQ-025 SHALL keep irq_timer asserted until the compare becomes false; it is a level, not a pulse.

Reset
REQ-026 SHALL reset mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, CTRL=0, prescale counter=0.
REQ-027 SHALL reset irq_timer=0, tmr_rvalid=0 and tmr_data=0.
REQ-028 SHALL abandon an in-flight read when reset asserts mid-operation; no tmr_rvalid follows reset release.

Configuration
REQ-029 With MACHINE_TIMER_MSIP_EN defined, SHALL add MSIP at 0x14 (bit0 RW, reset 0) and an output port irq_sw driven by bit0 through one register stage.
REQ-030 Without MACHINE_TIMER_MSIP_EN, SHALL omit irq_sw, and offset 0x14 SHALL behave as undefined.

Structure
REQ-031 SHALL place the register offsets, CTRL field positions and reset values in shared package machine_timer_pkg.
REQ-032 SHALL implement the prescaler as sub-module machine_timer_prescaler (inputs: en, div; output: tick).

Verification
REQ-033 Reset, then read 0x08 and 0x0C -> both return 32'hFFFF_FFFF; irq_timer=0.
REQ-034 Write CTRL=0x0000_0301 (DIV=3, EN=1) -> MTIME_LO increments once per 4 cycles; after 40 cycles it reads 10 +/-1.
REQ-035 Write MTIME_LO=0xFFFF_FFFF and MTIME_HI=0 with EN=1, DIV=0 -> next tick gives MTIME_HI=1, MTIME_LO=0.
REQ-036 MTIMECMP=100, MTIME=95, DIV=0 -> irq_timer rises exactly 6 cycles after EN is set; writing MTIMECMP_HI=1 drops it the next cycle.
REQ-037 Tick and a MTIME_LO write of 0x55 with ram_sel=4'b0001 in the same cycle -> byte0=0x55, other bytes keep pre-tick value, no increment that cycle.
REQ-038 With MACHINE_TIMER_MSIP_EN, write 0x14=1 -> irq_sw=1 one cycle later; write 0 -> irq_sw=0; a read of 0x18 returns 0.
